// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo
//   Stereo sample buffer in front of the I2S transmitter. The audio source
//   pushes {left,right} pairs with a valid/ready handshake. While playing,
//   each transmitter sample_pulse pops one pair onto DAC_Left/DAC_Right.
//   Playback waits until START_LEVEL pairs are buffered (priming). An
//   underflow either repeats the last pair or outputs silence.
//
// Ports
//   clk_in          system clock (shared with the transmitter)
//   reset_n         asynchronous active-low reset
//   flush           synchronous clear of contents and state (not the stats)
//   in_valid/in_ready/in_left/in_right   push handshake and pair data
//   sample_pulse    one-cycle pop request from the transmitter
//   DAC_Left/DAC_Right  registered output pair, updated one cycle after a pop
//   fifo_level      occupancy, 0..2**DEPTH_LOG2
//   playing         high while running
//   underflow       one-cycle pulse on a pop request with the FIFO empty
//   underflow_count saturating count of underflow events
module i2s_sample_fifo #(
  parameter int BITS           = 16,
  parameter int DEPTH_LOG2     = 4,
  parameter int START_LEVEL    = 4,
  parameter int UNDERFLOW_HOLD = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_left,
  input  logic [BITS-1:0]       in_right,
  input  logic                  sample_pulse,
  output logic [BITS-1:0]       DAC_Left,
  output logic [BITS-1:0]       DAC_Right,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  playing,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_START = (DEPTH_LOG2 + 1)'(START_LEVEL);

  typedef enum logic {
    PRIMING,
    RUNNING
  } state_t;

  state_t state, state_next;

  logic [2*BITS-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic [2*BITS-1:0]     head;
  logic                  push, pop_req, pop, uf_evt;

  // Ready looks only at the registered level, so a full FIFO refuses a push
  // even when a pop frees a slot in the same cycle.
  assign in_ready = (fifo_level != LVL_FULL);
  assign push     = in_valid & in_ready & ~flush;
  assign pop_req  = (state == RUNNING) & sample_pulse & ~flush;
  // An empty FIFO never pops, even if a push lands in the same cycle.
  assign pop      = pop_req & (fifo_level != '0);
  assign uf_evt   = pop_req & (fifo_level == '0);
  assign head     = mem[rd_ptr];
  assign playing  = (state == RUNNING);

  always_comb begin
    state_next = state;
    level_next = fifo_level;
    if (flush) begin
      state_next = PRIMING;
    end else if (state == PRIMING && fifo_level >= LVL_START) begin
      state_next = RUNNING;
    end
    case ({push, pop})
      2'b10:   level_next = fifo_level + 1'b1;
      2'b01:   level_next = fifo_level - 1'b1;
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state           <= PRIMING;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      DAC_Left        <= '0;
      DAC_Right       <= '0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        DAC_Left   <= '0;
        DAC_Right  <= '0;
        underflow  <= 1'b0;
      end else begin
        fifo_level <= level_next;
        underflow  <= uf_evt;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          DAC_Left  <= head[2*BITS-1:BITS];
          DAC_Right <= head[BITS-1:0];
        end
        if (uf_evt) begin
          if (underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 1'b1;
          end
          if (UNDERFLOW_HOLD == 0) begin
            DAC_Left  <= '0;
            DAC_Right <= '0;
          end
        end
      end
    end
  end

endmodule
